kftvga_text_writer: RTL and testbench
=====================================

Name: kftvga_text_writer

Overview:
- Character-stream console engine directly upstream of the text video controller's host bus port.
- Accepts one byte per valid/ready handshake and keeps a 60x80 cursor.
- Printable bytes become two VRAM byte writes: character code, then colour attribute.
- Handles CR, LF, BS and FF (clear screen) in hardware so a CPU or UART can drive the display as a dumb terminal.

Parameters:
- STROBE_CYCLES, 2: clocks that chip_select_n and write_enable_n stay low per byte write (legal range 1..15).
- COLUMNS, 80: text columns (fixed; not a design variable).
- ROWS, 60: text rows (fixed; not a design variable).

Ports:
- clock  input  1  system clock, same clock as the controller's bus port.
- reset_n  input  1  asynchronous, active-low reset.
- char_valid  input  1  upstream byte available.
- char_data  input  8  byte to process (character or control code).
- char_color  input  8  attribute sampled together with char_data on accept.
- char_ready  output  1  engine can accept a byte this cycle.
- cursor_row  output  6  current row, 0..59.
- cursor_col  output  7  current column, 0..79.
- busy  output  1  bus sequence in progress (write or clear).
- chip_select_n  output  1  controller chip select, active-low.
- read_enable_n  output  1  held 1 (engine never reads).
- write_enable_n  output  1  controller write strobe, active-low.
- address  output  14  VRAM byte address.
- data_bus_out  output  8  write data to controller.

Behaviour:
- Reset (async assert, sync release) values:
  - cursor_row=0, cursor_col=0.
  - chip_select_n=1, write_enable_n=1, read_enable_n=1.
  - address=0, data_bus_out=0.
  - busy=0, char_ready=0 while reset_n=0. char_ready goes to 1 on the first clock after release.
  - FSM state IDLE.
- Reset mid-sequence aborts the sequence immediately: strobes high, cursor to 0,0. A partially written cell is left as-is.
- Handshake:
  - Accept occurs on a clock edge with char_valid=1 and char_ready=1.
  - char_ready=1 only in IDLE.
  - char_data and char_color are latched on accept. Upstream may change them afterwards.
- Addressing:
  - cell = row*80 + col (13 bits, 0..4799).
  - Character byte address = cell*2. Colour byte address = cell*2+1. Maximum address is 9599.
- Byte write timing, with S = STROBE_CYCLES:
  - S cycles with chip_select_n=0, write_enable_n=0, address and data_bus_out stable.
  - Then 1 gap cycle with both strobes high and address/data held.
  - Each byte write therefore takes S+1 cycles.
- FSM states: IDLE, WR_CHAR, GAP_CHAR, WR_COLOR, GAP_COLOR, CLR_CHAR, CLR_GAP_C, CLR_COLOR, CLR_GAP_A.
- Printable byte (any value other than 0x08, 0x0A, 0x0C, 0x0D):
  - Sequence: IDLE -> WR_CHAR -> GAP_CHAR -> WR_COLOR -> GAP_COLOR -> IDLE.
  - The cursor advances on the edge leaving GAP_COLOR:
    - col+1.
    - At col 79: col=0, row+1.
    - At row 59, col 79: wrap to 0,0. There is no scrolling.
  - char_ready is high again 2*(S+1) cycles after the accept edge.
  - busy=1 in every non-IDLE state.
- 0x0D (CR): col=0 on the accept edge. No bus activity, stays IDLE.
- 0x0A (LF): row+1 (59 wraps to 0), col unchanged, on the accept edge. No bus activity.
- 0x08 (BS): no erase.
  - If col>0: col-1.
  - Else if row>0: row-1, col=79.
  - At 0,0: no change.
- 0x0C (FF): fills all 4800 cells with char 0x20 and attribute char_color.
  - Clear counter runs 0..4799 through CLR_CHAR/CLR_GAP_C/CLR_COLOR/CLR_GAP_A.
  - On the last gap: counter cleared, cursor set to 0,0, return to IDLE.
  - Total time 9600*(S+1) cycles. The cursor holds its old value until completion.
- char_valid while not ready: the byte is ignored (not queued). Upstream must hold it.
- cursor_row/cursor_col are registered and change only on the edges defined above.

Test Plan:
- Reset release, then 'A' (0x41) with colour 0x1F at 0,0 (S=2):
  - Writes addr 0 data 0x41, then addr 1 data 0x1F.
  - Each write has 2 low-strobe cycles and 1 gap.
  - char_ready returns 6 cycles after accept; cursor becomes 0,1.
- Cursor at 0,79, send 'B' -> writes addr 158/159, cursor becomes 1,0.
- Cursor at 59,79, send 'C' -> writes addr 9598/9599, cursor wraps to 0,0.
- Cursor at 5,10:
  - CR -> 5,0.
  - LF -> 6,0.
  - BS -> 5,79.
  - No strobe activity; char_ready stays 1 throughout.
- FF with colour 0x07:
  - Exactly 9600 write strobes at addresses 0..9599; even addresses carry 0x20, odd addresses carry 0x07.
  - busy high for 28800 cycles, then cursor at 0,0.
- Assert reset_n low in WR_COLOR of a printable write:
  - Strobes high immediately, cursor 0,0, char_ready=0 during reset.
  - After release, a new byte is accepted normally.

Source files
------------

// File: rtl/kftvga_text_writer.sv
// Character-stream console engine feeding the text controller's host bus port.
// Accepts one byte per valid/ready handshake, keeps a 60x80 cursor, turns
// printable bytes into a char write followed by an attribute write, and
// handles CR, LF, BS and FF (clear screen) locally.
//
// Ports:
//   clock, reset_n      system clock, async active-low reset
//   char_valid/ready    upstream byte handshake
//   char_data/color     byte and attribute, latched on accept
//   cursor_row/col      current cursor (registered)
//   busy                bus sequence (write or clear) in progress
//   chip_select_n, read_enable_n, write_enable_n, address, data_bus_out
//                       controller host bus (write-only)
module kftvga_text_writer #(
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    input  logic [7:0]  char_color,
    output logic        char_ready,
    output logic [5:0]  cursor_row,
    output logic [6:0]  cursor_col,
    output logic        busy,
    output logic        chip_select_n,
    output logic        read_enable_n,
    output logic        write_enable_n,
    output logic [13:0] address,
    output logic [7:0]  data_bus_out
);

    localparam int unsigned COLUMNS = 80;
    localparam int unsigned ROWS    = 60;
    localparam int unsigned CELLS   = COLUMNS * ROWS;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned ROW_W   = 6;
    localparam int unsigned COL_W   = 7;
    localparam int unsigned CELL_W  = 13;
    localparam int unsigned ADDR_W  = 14;

    localparam logic [7:0] CODE_BS = 8'h08;
    localparam logic [7:0] CODE_LF = 8'h0A;
    localparam logic [7:0] CODE_FF = 8'h0C;
    localparam logic [7:0] CODE_CR = 8'h0D;
    localparam logic [7:0] SPACE   = 8'h20;

    typedef enum logic [3:0] {
        IDLE, WR_CHAR, GAP_CHAR, WR_COLOR, GAP_COLOR,
        CLR_CHAR, CLR_GAP_C, CLR_COLOR, CLR_GAP_A
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [COL_W-1:0]    col_q, col_d;
    logic [ADDR_W-1:0]   address_q, address_d;
    logic [7:0]          data_q, data_d;
    logic [7:0]          color_q, color_d;
    logic [CELL_W-1:0]   clr_q, clr_d;
    logic                cs_n_q, we_n_q, busy_q, ready_q;
    logic                strobe_d;

    logic [CELL_W-1:0]   cell_c;
    logic [CELL_W-1:0]   clr_next_c;
    logic                strobe_done_c;
    logic                last_row_c;
    logic                last_col_c;

    // Linear cell index of the cursor and helper flags
    assign cell_c        = CELL_W'(row_q) * CELL_W'(COLUMNS) + CELL_W'(col_q);
    assign clr_next_c    = clr_q + CELL_W'(1);
    assign strobe_done_c = (cnt_q == CNT_W'(STROBE_CYCLES - 1));
    assign last_row_c    = (row_q == ROW_W'(ROWS - 1));
    assign last_col_c    = (col_q == COL_W'(COLUMNS - 1));

    // Next-state, cursor and bus payload
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        col_d     = col_q;
        address_d = address_q;
        data_d    = data_q;
        color_d   = color_q;
        clr_d     = clr_q;

        case (state_q)
            IDLE: begin
                if (char_valid && ready_q) begin
                    color_d = char_color;
                    case (char_data)
                        CODE_CR: col_d = '0;
                        CODE_LF: row_d = last_row_c ? '0 : row_q + ROW_W'(1);
                        CODE_BS: begin
                            if (col_q != '0) begin
                                col_d = col_q - COL_W'(1);
                            end else if (row_q != '0) begin
                                row_d = row_q - ROW_W'(1);
                                col_d = COL_W'(COLUMNS - 1);
                            end
                        end
                        CODE_FF: begin
                            state_d   = CLR_CHAR;
                            cnt_d     = '0;
                            clr_d     = '0;
                            address_d = '0;
                            data_d    = SPACE;
                        end
                        default: begin
                            state_d   = WR_CHAR;
                            cnt_d     = '0;
                            address_d = {cell_c, 1'b0};
                            data_d    = char_data;
                        end
                    endcase
                end
            end
            WR_CHAR, WR_COLOR, CLR_CHAR, CLR_COLOR: begin
                if (strobe_done_c) begin
                    cnt_d = '0;
                    case (state_q)
                        WR_CHAR:  state_d = GAP_CHAR;
                        WR_COLOR: state_d = GAP_COLOR;
                        CLR_CHAR: state_d = CLR_GAP_C;
                        default:  state_d = CLR_GAP_A;
                    endcase
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            GAP_CHAR, CLR_GAP_C: begin
                // Attribute byte sits at the odd address of the same cell
                state_d   = (state_q == GAP_CHAR) ? WR_COLOR : CLR_COLOR;
                address_d = {address_q[ADDR_W-1:1], 1'b1};
                data_d    = color_q;
            end
            GAP_COLOR: begin
                state_d = IDLE;
                if (last_col_c) begin
                    col_d = '0;
                    row_d = last_row_c ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_d = col_q + COL_W'(1);
                end
            end
            CLR_GAP_A: begin
                if (clr_q == CELL_W'(CELLS - 1)) begin
                    state_d = IDLE;
                    clr_d   = '0;
                    row_d   = '0;
                    col_d   = '0;
                end else begin
                    state_d   = CLR_CHAR;
                    clr_d     = clr_next_c;
                    address_d = {clr_next_c, 1'b0};
                    data_d    = SPACE;
                end
            end
            default: state_d = IDLE;
        endcase

        strobe_d = (state_d == WR_CHAR) || (state_d == WR_COLOR) ||
                   (state_d == CLR_CHAR) || (state_d == CLR_COLOR);
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            row_q     <= '0;
            col_q     <= '0;
            address_q <= '0;
            data_q    <= '0;
            color_q   <= '0;
            clr_q     <= '0;
            cs_n_q    <= 1'b1;
            we_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            col_q     <= col_d;
            address_q <= address_d;
            data_q    <= data_d;
            color_q   <= color_d;
            clr_q     <= clr_d;
            cs_n_q    <= !strobe_d;
            we_n_q    <= !strobe_d;
            busy_q    <= (state_d != IDLE);
            ready_q   <= (state_d == IDLE);
        end
    end

    assign char_ready     = ready_q;
    assign cursor_row     = row_q;
    assign cursor_col     = col_q;
    assign busy           = busy_q;
    assign chip_select_n  = cs_n_q;
    assign write_enable_n = we_n_q;
    assign read_enable_n  = 1'b1;
    assign address        = address_q;
    assign data_bus_out   = data_q;

endmodule

// File: tb/tb_kftvga_text_writer.sv
// Self-checking bench for kftvga_text_writer: a bus monitor captures each
// completed byte write, and a cursor/write model built on linear cell
// arithmetic predicts the cursor and the write stream.
module tb_kftvga_text_writer;

    localparam int S = 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        char_valid;
    logic [7:0]  char_data;
    logic [7:0]  char_color;
    logic        char_ready;
    logic [5:0]  cursor_row;
    logic [6:0]  cursor_col;
    logic        busy;
    logic        chip_select_n;
    logic        read_enable_n;
    logic        write_enable_n;
    logic [13:0] address;
    logic [7:0]  data_bus_out;

    kftvga_text_writer #(.STROBE_CYCLES(S)) dut (
        .clock(clock), .reset_n(reset_n),
        .char_valid(char_valid), .char_data(char_data), .char_color(char_color),
        .char_ready(char_ready), .cursor_row(cursor_row), .cursor_col(cursor_col),
        .busy(busy), .chip_select_n(chip_select_n), .read_enable_n(read_enable_n),
        .write_enable_n(write_enable_n), .address(address), .data_bus_out(data_bus_out)
    );

    always #5 clock = ~clock;

    typedef struct {int addr; int data;} wr_t;

    int checks = 0;
    int failures = 0;

    // Bus monitor: one entry per completed low-strobe window
    wr_t wr_q[$];
    int  low_cnt = 0;
    int  mon_addr = 0;
    int  mon_data = 0;
    int  strobe_err = 0;
    int  stable_err = 0;

    always @(negedge clock) begin
        if (write_enable_n !== chip_select_n || read_enable_n !== 1'b1) strobe_err++;
        if (chip_select_n === 1'b0) begin
            if (low_cnt == 0) begin
                mon_addr = int'(address);
                mon_data = int'(data_bus_out);
            end else if (int'(address) != mon_addr || int'(data_bus_out) != mon_data) begin
                stable_err++;
            end
            low_cnt++;
        end else if (low_cnt != 0) begin
            wr_q.push_back('{mon_addr, mon_data});
            if (low_cnt != S) strobe_err++;
            low_cnt = 0;
        end
    end

    // Reference model: cursor as a linear cell index on an 80x60 screen
    int  m_row = 0;
    int  m_col = 0;
    wr_t exp_q[$];

    function automatic void model_byte(input logic [7:0] d, input logic [7:0] c);
        int lin;
        lin = m_row * 80 + m_col;
        case (d)
            8'h0D: m_col = 0;
            8'h0A: m_row = (m_row + 1) % 60;
            8'h08: if (lin > 0) begin
                lin = lin - 1;
                m_row = lin / 80;
                m_col = lin % 80;
            end
            8'h0C: begin
                for (int i = 0; i < 4800; i++) begin
                    exp_q.push_back('{2 * i, 32'h20});
                    exp_q.push_back('{2 * i + 1, int'(c)});
                end
                m_row = 0;
                m_col = 0;
            end
            default: begin
                exp_q.push_back('{2 * lin, int'(d)});
                exp_q.push_back('{2 * lin + 1, int'(c)});
                lin = (lin + 1) % 4800;
                m_row = lin / 80;
                m_col = lin % 80;
            end
        endcase
    endfunction

    // Number of mismatching entries between observed and expected streams
    function automatic int count_bad(input int ws, input int es);
        int bad = 0;
        int n;
        n = exp_q.size() - es;
        if (wr_q.size() - ws != n) bad++;
        for (int i = 0; i < n; i++) begin
            if (ws + i >= wr_q.size()) bad++;
            else if (wr_q[ws + i].addr != exp_q[es + i].addr ||
                     wr_q[ws + i].data != exp_q[es + i].data) bad++;
        end
        return bad;
    endfunction

    int lat, bsy, mr, mc;

    // Present one byte, then wait until the engine is ready again
    task automatic send_byte(input logic [7:0] d, input logic [7:0] c,
                             output int lat_o, output int busy_o,
                             output int mid_row, output int mid_col);
        int guard = 0;
        int cyc = 0;
        while (char_ready !== 1'b1 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        if (char_ready !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL ready_timeout got=%b exp=1", char_ready);
        end
        char_valid = 1'b1;
        char_data  = d;
        char_color = c;
        @(posedge clock);
        #1;
        char_valid = 1'b0;
        char_data  = 8'($urandom);
        char_color = 8'($urandom);
        model_byte(d, c);
        busy_o  = 0;
        mid_row = int'(cursor_row);
        mid_col = int'(cursor_col);
        do begin
            @(negedge clock);
            cyc++;
            if (busy === 1'b1) busy_o++;
            if (cyc == 100) begin
                mid_row = int'(cursor_row);
                mid_col = int'(cursor_col);
            end
        end while (char_ready !== 1'b1 && cyc < 40000);
        lat_o = cyc - 1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        char_valid = 1'b0;
        char_data = 8'h00;
        char_color = 8'h00;
        repeat (3) @(negedge clock);
        checks++;
        if (cursor_row !== 6'd0 || cursor_col !== 7'd0) begin
            failures++;
            $display("FAIL reset_cursor got=%0d,%0d exp=0,0", cursor_row, cursor_col);
        end
        checks++;
        if ({chip_select_n, write_enable_n, read_enable_n} !== 3'b111) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=111", {chip_select_n, write_enable_n, read_enable_n});
        end
        checks++;
        if (address !== 14'd0 || data_bus_out !== 8'd0) begin
            failures++;
            $display("FAIL reset_bus got=%0d/%0h exp=0/0", address, data_bus_out);
        end
        checks++;
        if (busy !== 1'b0 || char_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy_ready got=%b%b exp=00", busy, char_ready);
        end
        reset_n = 1'b1;
        m_row = 0;
        m_col = 0;
        @(negedge clock);
        checks++;
        if (char_ready !== 1'b1) begin
            failures++;
            $display("FAIL ready_after_release got=%b exp=1", char_ready);
        end
    endtask

    task automatic test_first_char();
        int ws = wr_q.size();
        send_byte(8'h41, 8'h1F, lat, bsy, mr, mc);
        checks++;
        if (wr_q.size() != ws + 2 || wr_q[ws].addr != 0 || wr_q[ws].data != 32'h41 ||
            wr_q[ws + 1].addr != 1 || wr_q[ws + 1].data != 32'h1F) begin
            failures++;
            $display("FAIL first_writes got_n=%0d exp=addr0:41 addr1:1F", wr_q.size() - ws);
        end
        checks++;
        if (lat != 2 * (S + 1) || bsy != 2 * (S + 1)) begin
            failures++;
            $display("FAIL first_latency got=%0d/%0d exp=%0d", lat, bsy, 2 * (S + 1));
        end
        checks++;
        if (cursor_row !== 6'd0 || cursor_col !== 7'd1) begin
            failures++;
            $display("FAIL first_cursor got=%0d,%0d exp=0,1", cursor_row, cursor_col);
        end
    endtask

    task automatic test_row_wrap();
        int ws;
        send_byte(8'h0D, 8'h00, lat, bsy, mr, mc);
        send_byte(8'h0A, 8'h00, lat, bsy, mr, mc);
        send_byte(8'h08, 8'h00, lat, bsy, mr, mc);
        ws = wr_q.size();
        send_byte(8'h42, 8'h5A, lat, bsy, mr, mc);
        checks++;
        if (wr_q.size() != ws + 2 || wr_q[ws].addr != 158 || wr_q[ws + 1].addr != 159 ||
            wr_q[ws].data != 32'h42 || wr_q[ws + 1].data != 32'h5A) begin
            failures++;
            $display("FAIL rowwrap_writes got_n=%0d exp=158/159", wr_q.size() - ws);
        end
        checks++;
        if (cursor_row !== 6'd1 || cursor_col !== 7'd0) begin
            failures++;
            $display("FAIL rowwrap_cursor got=%0d,%0d exp=1,0", cursor_row, cursor_col);
        end
    endtask

    task automatic test_screen_wrap();
        int ws;
        repeat (58) send_byte(8'h0A, 8'h00, lat, bsy, mr, mc);
        send_byte(8'h08, 8'h00, lat, bsy, mr, mc);
        send_byte(8'h0A, 8'h00, lat, bsy, mr, mc);
        checks++;
        if (cursor_row !== 6'd59 || cursor_col !== 7'd79) begin
            failures++;
            $display("FAIL corner_cursor got=%0d,%0d exp=59,79", cursor_row, cursor_col);
        end
        ws = wr_q.size();
        send_byte(8'h43, 8'h33, lat, bsy, mr, mc);
        checks++;
        if (wr_q.size() != ws + 2 || wr_q[ws].addr != 9598 || wr_q[ws + 1].addr != 9599) begin
            failures++;
            $display("FAIL corner_writes got_n=%0d exp=9598/9599", wr_q.size() - ws);
        end
        checks++;
        if (cursor_row !== 6'd0 || cursor_col !== 7'd0) begin
            failures++;
            $display("FAIL screen_wrap got=%0d,%0d exp=0,0", cursor_row, cursor_col);
        end
    endtask

    task automatic test_controls();
        int ws, es, se;
        repeat (5) send_byte(8'h0A, 8'h00, lat, bsy, mr, mc);
        ws = wr_q.size();
        es = exp_q.size();
        for (int i = 0; i < 10; i++)
            send_byte(8'($urandom_range(8'h21, 8'h7E)), 8'($urandom), lat, bsy, mr, mc);
        checks++;
        if (count_bad(ws, es) != 0) begin
            failures++;
            $display("FAIL text_writes got_bad=%0d exp=0", count_bad(ws, es));
        end
        checks++;
        if (cursor_row !== 6'd5 || cursor_col !== 7'd10) begin
            failures++;
            $display("FAIL ctl_start got=%0d,%0d exp=5,10", cursor_row, cursor_col);
        end
        ws = wr_q.size();
        se = strobe_err;
        send_byte(8'h0D, 8'h00, lat, bsy, mr, mc);
        checks++;
        if (cursor_row !== 6'd5 || cursor_col !== 7'd0 || lat != 0) begin
            failures++;
            $display("FAIL cr got=%0d,%0d lat=%0d exp=5,0 lat=0", cursor_row, cursor_col, lat);
        end
        send_byte(8'h0A, 8'h00, lat, bsy, mr, mc);
        checks++;
        if (cursor_row !== 6'd6 || cursor_col !== 7'd0 || lat != 0) begin
            failures++;
            $display("FAIL lf got=%0d,%0d lat=%0d exp=6,0 lat=0", cursor_row, cursor_col, lat);
        end
        send_byte(8'h08, 8'h00, lat, bsy, mr, mc);
        checks++;
        if (cursor_row !== 6'd5 || cursor_col !== 7'd79 || lat != 0) begin
            failures++;
            $display("FAIL bs got=%0d,%0d lat=%0d exp=5,79 lat=0", cursor_row, cursor_col, lat);
        end
        checks++;
        if (wr_q.size() != ws || strobe_err != se || low_cnt != 0) begin
            failures++;
            $display("FAIL ctl_no_bus got=%0d writes exp=0", wr_q.size() - ws);
        end
    endtask

    task automatic test_random();
        logic [7:0] d;
        int ws, es, elat;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 7))
                0: d = 8'h0D;
                1: d = 8'h0A;
                2: d = 8'h08;
                default: begin
                    d = 8'($urandom);
                    if (d == 8'h0C) d = 8'h7E;
                end
            endcase
            elat = (d == 8'h0D || d == 8'h0A || d == 8'h08) ? 0 : 2 * (S + 1);
            repeat ($urandom_range(0, 2)) @(negedge clock);
            ws = wr_q.size();
            es = exp_q.size();
            send_byte(d, 8'($urandom), lat, bsy, mr, mc);
            checks++;
            if (cursor_row !== 6'(m_row) || cursor_col !== 7'(m_col)) begin
                failures++;
                $display("FAIL rand_cursor byte=%h got=%0d,%0d exp=%0d,%0d", d, cursor_row, cursor_col, m_row, m_col);
            end
            checks++;
            if (count_bad(ws, es) != 0) begin
                failures++;
                $display("FAIL rand_writes byte=%h got_bad=%0d exp=0", d, count_bad(ws, es));
            end
            checks++;
            if (lat != elat || bsy != elat) begin
                failures++;
                $display("FAIL rand_latency byte=%h got=%0d/%0d exp=%0d", d, lat, bsy, elat);
            end
        end
    endtask

    task automatic test_ignore_busy();
        int ws, es, guard;
        ws = wr_q.size();
        es = exp_q.size();
        char_valid = 1'b1;
        char_data  = 8'h58;
        char_color = 8'h4E;
        @(posedge clock);
        #1;
        model_byte(8'h58, 8'h4E);
        char_data = 8'h0D;
        repeat (3) @(negedge clock);
        char_valid = 1'b0;
        guard = 0;
        while (char_ready !== 1'b1 && guard < 100) begin
            @(negedge clock);
            guard++;
        end
        checks++;
        if (cursor_row !== 6'(m_row) || cursor_col !== 7'(m_col) || count_bad(ws, es) != 0) begin
            failures++;
            $display("FAIL ignore_busy got=%0d,%0d exp=%0d,%0d", cursor_row, cursor_col, m_row, m_col);
        end
    endtask

    task automatic test_back_to_back();
        int ws, es, bad_lat;
        ws = wr_q.size();
        es = exp_q.size();
        bad_lat = 0;
        for (int i = 0; i < 8; i++) begin
            send_byte(8'($urandom_range(8'h30, 8'h7A)), 8'($urandom), lat, bsy, mr, mc);
            if (lat != 2 * (S + 1)) bad_lat++;
        end
        checks++;
        if (count_bad(ws, es) != 0 || bad_lat != 0) begin
            failures++;
            $display("FAIL back_to_back got_bad=%0d lat_bad=%0d exp=0", count_bad(ws, es), bad_lat);
        end
        checks++;
        if (strobe_err != 0 || stable_err != 0) begin
            failures++;
            $display("FAIL strobe_shape got=%0d/%0d exp=0/0", strobe_err, stable_err);
        end
    endtask

    task automatic test_clear();
        int ws, es, old_row, old_col;
        send_byte(8'h0A, 8'h00, lat, bsy, mr, mc);
        old_row = int'(cursor_row);
        old_col = int'(cursor_col);
        ws = wr_q.size();
        es = exp_q.size();
        send_byte(8'h0C, 8'h07, lat, bsy, mr, mc);
        checks++;
        if (wr_q.size() - ws != 9600) begin
            failures++;
            $display("FAIL clear_count got=%0d exp=9600", wr_q.size() - ws);
        end
        checks++;
        if (count_bad(ws, es) != 0) begin
            failures++;
            $display("FAIL clear_data got_bad=%0d exp=0", count_bad(ws, es));
        end
        checks++;
        if (bsy != 9600 * (S + 1) || lat != 9600 * (S + 1)) begin
            failures++;
            $display("FAIL clear_busy got=%0d/%0d exp=%0d", bsy, lat, 9600 * (S + 1));
        end
        checks++;
        if (mr != old_row || mc != old_col) begin
            failures++;
            $display("FAIL clear_hold got=%0d,%0d exp=%0d,%0d", mr, mc, old_row, old_col);
        end
        checks++;
        if (cursor_row !== 6'd0 || cursor_col !== 7'd0) begin
            failures++;
            $display("FAIL clear_cursor got=%0d,%0d exp=0,0", cursor_row, cursor_col);
        end
    endtask

    task automatic test_reset_mid();
        int ws, se, ss;
        send_byte(8'h0A, 8'h00, lat, bsy, mr, mc);
        send_byte(8'h61, 8'h00, lat, bsy, mr, mc);
        char_valid = 1'b1;
        char_data  = 8'h5A;
        char_color = 8'h21;
        @(posedge clock);
        #1;
        char_valid = 1'b0;
        repeat (4) @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if (chip_select_n !== 1'b1 || write_enable_n !== 1'b1 || char_ready !== 1'b0 ||
            busy !== 1'b0 || cursor_row !== 6'd0 || cursor_col !== 7'd0) begin
            failures++;
            $display("FAIL abort got=cs%b we%b rdy%b busy%b %0d,%0d exp=cs1 we1 rdy0 busy0 0,0",
                     chip_select_n, write_enable_n, char_ready, busy, cursor_row, cursor_col);
        end
        repeat (2) @(negedge clock);
        checks++;
        if (char_ready !== 1'b0 || chip_select_n !== 1'b1) begin
            failures++;
            $display("FAIL abort_hold got=%b%b exp=01", char_ready, chip_select_n);
        end
        reset_n = 1'b1;
        m_row = 0;
        m_col = 0;
        @(negedge clock);
        ws = wr_q.size();
        se = strobe_err;
        ss = stable_err;
        send_byte(8'h51, 8'h6C, lat, bsy, mr, mc);
        checks++;
        if (wr_q.size() != ws + 2 || wr_q[ws].addr != 0 || wr_q[ws].data != 32'h51 ||
            wr_q[ws + 1].addr != 1 || wr_q[ws + 1].data != 32'h6C || strobe_err != se || stable_err != ss) begin
            failures++;
            $display("FAIL post_abort_writes got_n=%0d exp=addr0:51 addr1:6C", wr_q.size() - ws);
        end
        checks++;
        if (cursor_row !== 6'd0 || cursor_col !== 7'd1 || lat != 2 * (S + 1)) begin
            failures++;
            $display("FAIL post_abort_cursor got=%0d,%0d lat=%0d exp=0,1 lat=%0d",
                     cursor_row, cursor_col, lat, 2 * (S + 1));
        end
    endtask

    initial begin
        test_reset();
        test_first_char();
        test_row_wrap();
        test_screen_wrap();
        test_controls();
        test_random();
        test_ignore_busy();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
